// File: rtl/axl_ctrl_pkg.sv
// Shared state codes and mode constants for the Axiline training sequencer.
package axl_ctrl_pkg;
  localparam int INST_W = 3;

  typedef enum logic [INST_W-1:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_INIT_IP = 3'd2,
    S_IP      = 3'd3,
    S_COMB    = 3'd4,
    S_PIPE    = 3'd5,
    S_RSVD    = 3'd6,
    S_FLUSH   = 3'd7
  } state_t;

  localparam logic MODE_TRAIN = 1'b0;
  localparam logic MODE_INFER = 1'b1;
endpackage

// File: rtl/axl_mod_counter.sv
// Modulo-MOD up counter with synchronous clear (priority) and terminal-count flag.
module axl_mod_counter #(
  parameter int W   = 3,
  parameter int MOD = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         tc
);
  assign tc = (cnt == W'(MOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= tc ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/axl_train_ctrl.sv
// Axiline train/inference sequencer: sample loop, stall, abort, done handshake, SGD tail flush.
// Optional multi-epoch training enabled by defining AXL_TRAIN_CTRL_EPOCH_EN.
module axl_train_ctrl #(
  parameter int NUM_CYCLE     = 8,
  parameter int LOG_NUM_CYCLE = $clog2(NUM_CYCLE),
  parameter int SAMPLE_W      = 16,
  parameter int INST_W        = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     mode,
  input  logic [SAMPLE_W-1:0]      num_samples,
`ifdef AXL_TRAIN_CTRL_EPOCH_EN
  input  logic [7:0]               num_epochs,
  output logic [7:0]               epoch_idx,
`endif
  input  logic                     stall,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic [INST_W-1:0]        inst,
  output logic                     sel,
  output logic                     step,
  output logic [LOG_NUM_CYCLE-1:0] xw1_addr,
  output logic [LOG_NUM_CYCLE-1:0] xw2_addr,
  output logic [SAMPLE_W-1:0]      sample_idx
);
  import axl_ctrl_pkg::*;

  state_t              state, state_nx;
  logic                mode_q;
  logic [SAMPLE_W-1:0] n_q;
  logic                accept, done_nx, idx_inc, idx_clr;
  logic                cnt_en, sgd_en, cnt_clr, cnt_tc, sgd_tc;
`ifdef AXL_TRAIN_CTRL_EPOCH_EN
  logic [7:0]          ep_q;
  logic                ep_inc, ep_clr;
`endif

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    done_nx  = 1'b0;
    idx_inc  = 1'b0;
    idx_clr  = 1'b0;
    cnt_en   = 1'b0;
    sgd_en   = 1'b0;
    step     = 1'b0;
`ifdef AXL_TRAIN_CTRL_EPOCH_EN
    ep_inc   = 1'b0;
    ep_clr   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          if (num_samples != '0) begin
            state_nx = S_INIT;
            accept   = 1'b1;
`ifdef AXL_TRAIN_CTRL_EPOCH_EN
            ep_clr   = 1'b1;
`endif
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      S_INIT: begin
        step   = !stall;
        cnt_en = !stall;
        if (!stall && cnt_tc) state_nx = S_INIT_IP;
      end
      S_INIT_IP, S_IP, S_PIPE: begin
        step   = !stall;
        cnt_en = !stall;
        sgd_en = !stall && (state == S_PIPE);
        if (!stall && cnt_tc) begin
          state_nx = S_COMB;
          idx_inc  = 1'b1;
        end
      end
      S_COMB: begin
        step = 1'b1;
        if (sample_idx < n_q)         state_nx = (mode_q == MODE_INFER) ? S_IP : S_PIPE;
        else if (mode_q == MODE_TRAIN) state_nx = S_FLUSH;
        else begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end
      end
      S_FLUSH: begin
        step   = !stall;
        sgd_en = !stall;
        if (!stall && sgd_tc) begin
`ifdef AXL_TRAIN_CTRL_EPOCH_EN
          // Further epochs reuse the loaded weights, so skip INIT.
          if (epoch_idx < ep_q - 8'd1) begin
            state_nx = S_INIT_IP;
            idx_clr  = 1'b1;
            ep_inc   = 1'b1;
          end else begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
          end
`else
          state_nx = S_IDLE;
          done_nx  = 1'b1;
`endif
        end
      end
      default: state_nx = S_IDLE;
    endcase

    if (abort && state != S_IDLE) begin
      state_nx = S_IDLE;
      done_nx  = 1'b0;
      idx_inc  = 1'b0;
      idx_clr  = 1'b1;
      cnt_en   = 1'b0;
      sgd_en   = 1'b0;
`ifdef AXL_TRAIN_CTRL_EPOCH_EN
      ep_inc   = 1'b0;
      ep_clr   = 1'b1;
`endif
    end
  end

  // Counters are forced to zero whenever the sequencer heads back to IDLE.
  assign cnt_clr = (state_nx == S_IDLE);

  axl_mod_counter #(.W(LOG_NUM_CYCLE), .MOD(NUM_CYCLE)) u_counter (
    .clk(clk), .rst(rst), .en(cnt_en), .clr(cnt_clr), .cnt(xw1_addr), .tc(cnt_tc)
  );

  axl_mod_counter #(.W(LOG_NUM_CYCLE), .MOD(NUM_CYCLE)) u_sgd_counter (
    .clk(clk), .rst(rst), .en(sgd_en), .clr(cnt_clr), .cnt(xw2_addr), .tc(sgd_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      mode_q     <= MODE_TRAIN;
      n_q        <= '0;
      sample_idx <= '0;
      done       <= 1'b0;
      sel        <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= done_nx;
      sel   <= (state == S_INIT_IP || state == S_IP || state == S_PIPE) &&
               (xw1_addr != '0) && !stall;
      if (accept) begin
        mode_q     <= mode;
        n_q        <= num_samples;
        sample_idx <= '0;
      end else if (idx_clr) begin
        sample_idx <= '0;
      end else if (idx_inc) begin
        sample_idx <= sample_idx + 1'b1;
      end
    end
  end

`ifdef AXL_TRAIN_CTRL_EPOCH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ep_q      <= 8'd1;
      epoch_idx <= '0;
    end else begin
      if (accept) ep_q <= (num_epochs == 8'd0) ? 8'd1 : num_epochs;
      if (ep_clr)      epoch_idx <= '0;
      else if (ep_inc) epoch_idx <= epoch_idx + 1'b1;
    end
  end
`endif

  assign busy = (state != S_IDLE);
  assign inst = INST_W'(state);
endmodule
